// File: rtl/tri_pkg.sv
// Shared definitions for the triangle twice-area scheduler: default sizes,
// derived datapath widths and the FSM state encoding.
package tri_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 11;

    // Difference of two W-bit signed coordinates needs one extra bit.
    function automatic int diff_w(input int w);
        return w + 1;
    endfunction

    // (W+1)-bit difference times W-bit coordinate.
    function automatic int prod_w(input int w);
        return 2 * w + 1;
    endfunction

    // Sum of three products, two guard bits so it can never wrap.
    function automatic int sum_w(input int w);
        return 2 * w + 3;
    endfunction

    // Magnitude of the sum drops the sign bit.
    function automatic int area_w(input int w);
        return 2 * w + 2;
    endfunction

    // Requester index width, at least one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIFF_W_DEF = diff_w(W_DEF);
    localparam int PROD_W_DEF = prod_w(W_DEF);
    localparam int SUM_W_DEF  = sum_w(W_DEF);
    localparam int AREA_W_DEF = area_w(W_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        T1    = 3'd2,
        T2    = 3'd3,
        T3    = 3'd4,
        SUM   = 3'd5,
        ABS   = 3'd6,
        DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/tri_term.sv
// Shared term unit: p = (a - b) * c, full precision, purely combinational.
module tri_term
    import tri_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic signed [W-1:0]         a,
    input  logic signed [W-1:0]         b,
    input  logic signed [W-1:0]         c,
    output logic signed [prod_w(W)-1:0] p
);

    localparam int DW = diff_w(W);
    localparam int PW = prod_w(W);

    logic signed [DW-1:0] diff;
    logic        [PW-1:0] diff_ext;
    logic        [PW-1:0] c_ext;

    // Sign-extend both factors to the product width; the low PW bits of the
    // product are then correct two's complement regardless of signedness.
    always_comb begin
        diff     = {a[W-1], a} - {b[W-1], b};
        diff_ext = {{(PW-DW){diff[DW-1]}}, diff};
        c_ext    = {{(PW-W){c[W-1]}}, c};
        p        = diff_ext * c_ext;
    end

endmodule

// File: rtl/tri_area_sched.sv
// Round-robin scheduler that grants one requester at a time, latches its
// triangle and computes twice the absolute area with one shared term unit.
// All state advances on the falling clock edge.
module tri_area_sched
    import tri_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*6*W-1:0]      vtx,
    output logic [N_REQ-1:0]          gnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [id_w(N_REQ)-1:0]    out_id,
    output logic [area_w(W)-1:0]      area2,
    output logic                      degen,
    output logic                      busy
);

    localparam int IDW = id_w(N_REQ);
    localparam int PW  = prod_w(W);
    localparam int SW  = sum_w(W);
    localparam int AW  = area_w(W);
    localparam int VW  = 6 * W;

    state_t state;
    state_t next_state;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick;
    logic           found;
    logic [VW-1:0]  sel_vtx;
    logic [VW-1:0]  lat;

    logic signed [W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
    logic signed [W-1:0] ta, tb, tc;
    logic signed [PW-1:0] term;
    logic signed [PW-1:0] t1, t2, t3;
    logic signed [SW-1:0] s_r;
    logic [AW-1:0]        area_nx;
    logic [AW-1:0]        area_r;
    logic                 degen_r;
    logic [IDW-1:0]       id_r;

    // Search upward from the last granted index, wrapping; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDW-1:0]   last);
        logic           hit;
        logic [IDW-1:0] sel;
        int             idx;
        hit = 1'b0;
        sel = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!hit && r[idx]) begin
                hit = 1'b1;
                sel = IDW'(idx);
            end
        end
        return {hit, sel};
    endfunction

    assign {found, pick} = rr_pick(req, ptr);

    // Pick out the vertex bundle of the currently selected requester.
    always_comb begin
        sel_vtx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IDW'(i)) begin
                sel_vtx = vtx[i*VW +: VW];
            end
        end
    end

    assign p1x = lat[5*W +: W];
    assign p1y = lat[4*W +: W];
    assign p2x = lat[3*W +: W];
    assign p2y = lat[2*W +: W];
    assign p3x = lat[1*W +: W];
    assign p3y = lat[0 +: W];

    // Steer the latched coordinates into the single term unit per phase.
    always_comb begin
        ta = p2y;
        tb = p3y;
        tc = p1x;
        case (state)
            T2: begin
                ta = p3y;
                tb = p1y;
                tc = p2x;
            end
            T3: begin
                ta = p1y;
                tb = p2y;
                tc = p3x;
            end
            default: ;
        endcase
    end

    tri_term #(.W(W)) u_term (
        .a (ta),
        .b (tb),
        .c (tc),
        .p (term)
    );

    // Magnitude of the sum; negation is only needed on the low AW bits.
    always_comb begin
        area_nx = s_r[AW-1:0];
        if (s_r[SW-1]) begin
            area_nx = (~s_r[AW-1:0]) + AW'(1);
        end
    end

    // State register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and FSM-decoded outputs.
    always_comb begin
        next_state = state;
        gnt        = '0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (|req) next_state = GRANT;
            GRANT: begin
                if (found) begin
                    gnt[pick]  = 1'b1;
                    next_state = T1;
                end else begin
                    next_state = IDLE;
                end
            end
            T1:    next_state = T2;
            T2:    next_state = T3;
            T3:    next_state = SUM;
            SUM:   next_state = ABS;
            ABS:   next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers: latch job, accumulate terms, sum and take magnitude.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= IDW'(N_REQ - 1);
            lat     <= '0;
            id_r    <= '0;
            t1      <= '0;
            t2      <= '0;
            t3      <= '0;
            s_r     <= '0;
            area_r  <= '0;
            degen_r <= 1'b0;
        end else begin
            case (state)
                GRANT: begin
                    if (found) begin
                        lat  <= sel_vtx;
                        id_r <= pick;
                        ptr  <= pick;
                    end
                end
                T1:  t1 <= term;
                T2:  t2 <= term;
                T3:  t3 <= term;
                SUM: s_r <= {{2{t1[PW-1]}}, t1} + {{2{t2[PW-1]}}, t2}
                          + {{2{t3[PW-1]}}, t3};
                ABS: begin
                    area_r  <= area_nx;
                    degen_r <= (s_r == '0);
                end
                default: ;
            endcase
        end
    end

    assign area2  = area_r;
    assign out_id = id_r;
    assign degen  = degen_r & (state == DONE);

endmodule

// File: tb/tb_tri_area_sched.sv
// Directed bench for tri_area_sched: a vector table of single-requester
// triangles plus hand-written arbitration, backpressure and reset sequences.
module tb_tri_area_sched;

    localparam int N   = 4;
    localparam int W   = 11;
    localparam int IDW = 2;
    localparam int AW  = 2 * W + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*6*W-1:0]  vtx;
    logic [N-1:0]      gnt;
    logic              out_valid;
    logic              out_ready;
    logic [IDW-1:0]    out_id;
    logic [AW-1:0]     area2;
    logic              degen;
    logic              busy;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int idx;
        int p1x, p1y, p2x, p2y, p3x, p3y;
        int area;
        int dg;
    } vec_t;

    vec_t vecs[7];

    tri_area_sched #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .vtx       (vtx),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .area2     (area2),
        .degen     (degen),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Step to just after the next active (falling) edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setTri(input int idx, input int p1x, input int p1y,
                          input int p2x, input int p2y, input int p3x,
                          input int p3y);
        int b;
        b = idx * 6 * W;
        vtx[b + 5*W +: W] = p1x[W-1:0];
        vtx[b + 4*W +: W] = p1y[W-1:0];
        vtx[b + 3*W +: W] = p2x[W-1:0];
        vtx[b + 2*W +: W] = p2y[W-1:0];
        vtx[b + 1*W +: W] = p3x[W-1:0];
        vtx[b +: W]       = p3y[W-1:0];
    endtask

    task automatic applyStimulus(input vec_t v);
        setTri(v.idx, v.p1x, v.p1y, v.p2x, v.p2y, v.p3x, v.p3y);
        req[v.idx] = 1'b1;
    endtask

    task automatic waitGnt(output logic [N-1:0] g);
        int k;
        k = 0;
        while (gnt == '0 && k < 30) begin
            tick();
            k++;
        end
        g = gnt;
        checkOutput("gnt_seen", 32'(gnt != '0), 1);
    endtask

    // One full job from grant to result; leaves DONE if out_ready is high.
    task automatic runJob(input int exp_idx, input int exp_area,
                          input int exp_dg, input bit drop, input string tag);
        logic [N-1:0] g;
        int n;
        waitGnt(g);
        checkOutput({tag, "_gnt"}, 32'(g), 32'(1 << exp_idx));
        tick();
        if (drop) req[exp_idx] = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_latency"}, n, 5);
        checkOutput({tag, "_area2"}, 32'(area2), exp_area);
        checkOutput({tag, "_id"}, 32'(out_id), exp_idx);
        checkOutput({tag, "_degen"}, 32'(degen), exp_dg);
        checkOutput({tag, "_busy"}, 32'(busy), 1);
        if (out_ready) begin
            tick();
            checkOutput({tag, "_valid_drop"}, 32'(out_valid), 0);
            checkOutput({tag, "_idle"}, 32'(busy), 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        vecs[0] = '{0,     0,     0,     4,     0,     0,     3,      12, 0};
        vecs[1] = '{1,     0,     0,     0,     3,     4,     0,      12, 0};
        vecs[2] = '{3, -1024, -1024,  1023, -1024, -1024,  1023, 4190209, 0};
        vecs[3] = '{2,     0,     0,     1,     1,     2,     2,       0, 1};
        vecs[4] = '{1,    -5,     2,     3,    -7,     6,     4,     115, 0};
        vecs[5] = '{0,     7,     7,     7,     7,     7,     7,       0, 1};
        vecs[6] = '{2,  1023,  1023, -1024,  1023,  1023, -1024, 4190209, 0};

        rst_n     = 1'b0;
        req       = '0;
        vtx       = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rst_gnt", 32'(gnt), 0);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_area2", 32'(area2), 0);
        checkOutput("rst_degen", 32'(degen), 0);
        checkOutput("rst_id", 32'(out_id), 0);
        rst_n = 1'b1;
        tick();

        // Single-requester triangles from the table.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            runJob(vecs[i].idx, vecs[i].area, vecs[i].dg, 1'b1,
                   $sformatf("vec%0d", i));
        end

        // All four requesting continuously: round-robin from requester 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        setTri(0, 0, 0, 4, 0, 0, 3);
        setTri(1, -5, 2, 3, -7, 6, 4);
        setTri(2, 0, 0, 1, 1, 2, 2);
        setTri(3, 0, 0, 0, 3, 4, 0);
        req = 4'b1111;
        runJob(0, 12, 0, 1'b0, "rr0");
        runJob(1, 115, 0, 1'b0, "rr1");
        runJob(2, 0, 1, 1'b0, "rr2");
        runJob(3, 12, 0, 1'b0, "rr3");
        runJob(0, 12, 0, 1'b0, "rr4");
        req = '0;

        // Backpressure in DONE; a short-lived request must never be served.
        out_ready = 1'b0;
        applyStimulus(vecs[0]);
        runJob(0, 12, 0, 1'b1, "hold");
        setTri(1, -5, 2, 3, -7, 6, 4);
        req[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) req[3] = 1'b1;
            if (i == 5) req[3] = 1'b0;
            tick();
            checkOutput("hold_valid", 32'(out_valid), 1);
            checkOutput("hold_area2", 32'(area2), 12);
            checkOutput("hold_id", 32'(out_id), 0);
            checkOutput("hold_gnt", 32'(gnt), 0);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("release_valid", 32'(out_valid), 0);
        checkOutput("release_idle", 32'(busy), 0);
        runJob(1, 115, 0, 1'b1, "after_hold");
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gnt != '0 || busy) seen++;
        end
        checkOutput("dropped_req_ignored", seen, 0);

        // Reset in the middle of a job.
        setTri(0, -1024, -1024, 1023, -1024, -1024, 1023);
        req = 4'b0001;
        begin
            logic [N-1:0] g;
            waitGnt(g);
            checkOutput("mid_gnt", 32'(g), 1);
        end
        tick();
        req = '0;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_gnt", 32'(gnt), 0);
        checkOutput("mid_rst_valid", 32'(out_valid), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_area2", 32'(area2), 0);
        checkOutput("mid_rst_degen", 32'(degen), 0);
        checkOutput("mid_rst_id", 32'(out_id), 0);
        tick();
        checkOutput("mid_rst_no_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        req   = 4'b1111;
        runJob(0, 4190209, 0, 1'b0, "post_rst");
        req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tri_area_sched.md
TRI_AREA_SCHED -- requirements
Module: tri_area_sched

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: W, 11, signed coordinate width.
REQ-003 clk  in  1  single clock; all state updates on falling edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  N_REQ  per-requester request, level, held until its gnt bit pulses.
REQ-006 vtx  in  N_REQ*6*W  per-requester {p1x,p1y,p2x,p2y,p3x,p3y}, signed, stable while req high.
REQ-007 gnt  out  N_REQ  one-hot one-cycle pulse; vertices of that requester latched this cycle.
REQ-008 out_valid  out  1  result available, held until accepted.
REQ-009 out_ready  in  1  consumer accepts result when out_valid and out_ready are both high.
REQ-010 out_id  out  clog2(N_REQ)  index of requester owning the result.
REQ-011 area2  out  2*W+2  unsigned twice-area |p1x(p2y-p3y)+p2x(p3y-p1y)+p3x(p1y-p2y)|.
REQ-012 degen  out  1  high with out_valid when area2 == 0.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, GRANT, T1, T2, T3, SUM, ABS, DONE.
REQ-015 IDLE -> GRANT when any req bit is high; otherwise stay.
REQ-016 GRANT: round-robin pick, searching from last-granted index +1 upward, wrapping; pulse gnt, latch 6 coordinates and id -> T1.
REQ-017 Only one shared term unit; T1/T2/T3 compute (p2y-p3y)*p1x, (p3y-p1y)*p2x, (p1y-p2y)*p3x into t1/t2/t3.
REQ-018 Difference W+1 bits signed, product 2W+1 bits signed, sum 2W+3 bits signed; no truncation anywhere.
REQ-019 SUM: s = t1+t2+t3; ABS: area2 = |s|, degen = (s==0) -> DONE.
REQ-020 DONE: out_valid high, area2/out_id/degen stable; on out_ready -> IDLE with out_valid low next cycle.
REQ-021 Latency: out_valid rises 5 falling edges after the gnt edge; throughput one triangle per >=7 cycles.
REQ-022 Requests arriving or dropping during T1..DONE do not affect the in-flight job; no gnt outside GRANT.
REQ-023 req bit dropped before being granted: no gnt, no result for that requester.
REQ-024 Only one requester active: granted every time regardless of pointer.
REQ-025 Round-robin pointer updates only in GRANT; after reset it points so requester 0 has highest priority.
REQ-026 out_ready high outside DONE is ignored.

Reset
REQ-027 rst_n low, asynchronously at any state: state=IDLE, gnt=0, out_valid=0, busy=0, area2=0, degen=0, out_id=0, pointer reset, t1..t3 cleared.
REQ-028 Reset mid-job discards the job with no result; the first grant after release follows REQ-025.

Structure
REQ-029 Shared package tri_pkg holds W, N_REQ defaults, derived widths (diff, product, sum, area) and FSM state encoding.
REQ-030 One sub-module tri_term: combinational (a-b)*c with widths per REQ-018, instantiated once.
REQ-031 Arbitration (round-robin search) stays in tri_area_sched as a function, not a module.

Verification
REQ-032 Req0 only, (0,0),(4,0),(0,3), out_ready=1 -> gnt=0001, 5 edges later out_valid, area2=12, out_id=0, degen=0.
REQ-033 Same triangle clockwise (0,0),(0,3),(4,0) -> area2=12 (absolute value).
REQ-034 Extremes (-1024,-1024),(1023,-1024),(-1024,1023) -> area2=4190209, no overflow.
REQ-035 req=1111 held, out_ready=1 -> grant order 0,1,2,3,0; collinear (0,0),(1,1),(2,2) on req2 -> area2=0, degen=1.
REQ-036 out_ready=0 for 10 cycles in DONE -> outputs stable, no new gnt; then out_ready=1 -> IDLE and next grant.
REQ-037 rst_n low during T2 -> all outputs zero immediately, no out_valid; after release req0 granted first.
